// File: rtl/fifo_param_pkg.sv
// Shared FIFO parameters plus the write-arbiter state encoding and default limits.
package fifo_param_pkg;

  localparam int FIFO_WIDTH    = 32;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_STALL_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  // Index width that stays legal when there is only one requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_picker
  import fifo_param_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               any,
  output logic [IW-1:0]      winner
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW:0]          off;
  logic [IW:0]          sum;

  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[NUM_REQ-1:0];
    any = |req;
    off = '0;
    // Scan downwards so the lowest rotated index wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IW+1)'(i);
    end
    sum = off + {1'b0, rr_ptr};
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    winner = sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; a beat is written the same cycle it is
// accepted, a full FIFO stalls the owner, and a stall lasting STALL_MAX cycles revokes the grant.
module fifo_wr_arbiter
  import fifo_param_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int STALL_MAX = DEF_STALL_MAX,
  parameter int IW        = idx_width(NUM_REQ)
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]  wr_data,
  input  logic [NUM_REQ-1:0]                  last,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [IW-1:0]                       owner_id,
  output logic                                fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]               fifo_wr_data,
  input  logic                                fifo_full,
  input  logic                                fifo_wr_err,
  output logic                                ovf_err,
  output logic [7:0]                          ovf_cnt
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int SW = $clog2(STALL_MAX + 1);

  arb_state_t          state, state_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic [IW-1:0]       owner_nxt;
  logic [IW-1:0]       rr_ptr, rr_ptr_nxt, ptr_after;
  logic [BW-1:0]       beat_cnt, beat_nxt;
  logic [SW-1:0]       stall_cnt, stall_nxt;
  logic                pick_any;
  logic [IW-1:0]       pick_idx;
  logic                own_req, own_last, acc, release_gnt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .winner (pick_idx)
  );

  assign own_req      = req[owner_id];
  assign own_last     = last[owner_id];
  assign acc          = (state == BURST) && own_req && !fifo_full;
  assign fifo_wr_en   = acc;
  assign fifo_wr_data = acc ? wr_data[owner_id] : '0;
  assign ptr_after    = (owner_id == IW'(NUM_REQ - 1)) ? '0 : owner_id + IW'(1);

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    owner_nxt   = owner_id;
    rr_ptr_nxt  = rr_ptr;
    beat_nxt    = beat_cnt;
    stall_nxt   = stall_cnt;
    release_gnt = 1'b0;

    case (state)
      IDLE: begin
        if (pick_any && !fifo_full) begin
          state_nxt          = BURST;
          gnt_nxt            = '0;
          gnt_nxt[pick_idx]  = 1'b1;
          owner_nxt          = pick_idx;
          beat_nxt           = '0;
        end
      end
      BURST: begin
        if (acc) begin
          if (own_last || beat_cnt == BW'(MAX_BURST - 1)) release_gnt = 1'b1;
          else beat_nxt = beat_cnt + BW'(1);
        end else if (!own_req) begin
          release_gnt = 1'b1;
        end else begin
          state_nxt = STALL;
          stall_nxt = SW'(1);
        end
      end
      STALL: begin
        // A vanished owner is released even while the FIFO stays full.
        if (!own_req) release_gnt = 1'b1;
        else if (!fifo_full) state_nxt = BURST;
        else if (stall_cnt == SW'(STALL_MAX)) release_gnt = 1'b1;
        else stall_nxt = stall_cnt + SW'(1);
      end
      default: state_nxt = IDLE;
    endcase

    if (release_gnt) begin
      state_nxt  = IDLE;
      gnt_nxt    = '0;
      owner_nxt  = '0;
      rr_ptr_nxt = ptr_after;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      gnt       <= '0;
      owner_id  <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      owner_id  <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      beat_cnt  <= beat_nxt;
      stall_cnt <= stall_nxt;
    end
  end

  // Overflow reporting is independent of arbitration.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_err <= 1'b0;
      ovf_cnt <= '0;
    end else if (fifo_wr_err) begin
      ovf_err <= 1'b1;
      if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(gnt));
  a_no_wr_full: assert property (@(posedge CLK) disable iff (RST) !(fifo_wr_en && fifo_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a rule-level reference model predicts grants and writes, a monitor scores them.
module tb_fifo_wr_arbiter;
  import fifo_param_pkg::*;

  localparam int N  = 4;
  localparam int MB = 8;
  localparam int SM = 16;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [N-1:0]         req = '0;
  logic [N-1:0][31:0]   wr_data = '0;
  logic [N-1:0]         last = '0;
  logic [N-1:0]         gnt;
  logic [1:0]           owner_id;
  logic                 fifo_wr_en;
  logic [31:0]          fifo_wr_data;
  logic                 fifo_full = 1'b0;
  logic                 fifo_wr_err = 1'b0;
  logic                 ovf_err;
  logic [7:0]           ovf_cnt;

  fifo_wr_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .STALL_MAX(SM)) dut (
    .CLK(CLK), .RST(RST), .req(req), .wr_data(wr_data), .last(last),
    .gnt(gnt), .owner_id(owner_id), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .fifo_wr_err(fifo_wr_err), .ovf_err(ovf_err), .ovf_cnt(ovf_cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  logic [31:0] exp_q[$];

  // Reference model: who owns the port, whether it is stalled, beats so far, stall length,
  // next starting point for the round-robin search, and the overflow bookkeeping.
  int m_owner = -1;
  bit m_stalled = 0;
  int m_beats = 0;
  int m_stall = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_stalled = 0;
  endfunction

  // Model evaluation and registered-output checks, once per cycle with inputs stable.
  always @(negedge CLK) begin
    if (RST) begin
      m_owner = -1; m_stalled = 0; m_beats = 0; m_stall = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
      exp_q.delete();
    end else begin
      logic [N-1:0] exp_gnt;
      bit wr;
      exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      check("gnt", gnt, exp_gnt);
      check("owner_id", owner_id, (m_owner >= 0) ? m_owner : 0);
      check("ovf_err", ovf_err, m_err);
      check("ovf_cnt", ovf_cnt, m_cnt);
      wr = (m_owner >= 0) && !m_stalled && req[m_owner] && !fifo_full;
      if (wr) exp_q.push_back(wr_data[m_owner]);

      if (fifo_wr_err) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (m_owner < 0) begin
        if (req != 0 && !fifo_full) begin
          for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          end
          m_beats = 0;
          m_stalled = 0;
        end
      end else if (!m_stalled) begin
        if (wr) begin
          m_beats++;
          if (last[m_owner] || m_beats == MB) m_release();
        end else if (!req[m_owner]) begin
          m_release();
        end else begin
          m_stalled = 1;
          m_stall = 1;
        end
      end else begin
        if (!req[m_owner]) m_release();
        else if (!fifo_full) m_stalled = 0;
        else if (m_stall == SM) m_release();
        else m_stall++;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT writes, flags writes that never came.
  always @(negedge CLK) begin
    #2;
    if (!RST) begin
      if (fifo_wr_en) begin
        wr_seen++;
        check("wr_while_full", fifo_full, 1'b0);
        if (exp_q.size() == 0) check("unexpected_write", 1'b1, 1'b0);
        else check("wr_data", fifo_wr_data, exp_q.pop_front());
      end
      check("missing_write", exp_q.size(), 0);
      exp_q.delete();
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic f, input logic e);
    @(posedge CLK);
    #1;
    req = r; last = l; fifo_full = f; fifo_wr_err = e;
    for (int i = 0; i < N; i++) wr_data[i] = $urandom;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("rst_gnt", gnt, '0);
    check("rst_owner", owner_id, '0);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_wr_data", fifo_wr_data, '0);
    check("rst_ovf_err", ovf_err, 1'b0);
    check("rst_ovf_cnt", ovf_cnt, '0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    req = '0; last = '0; fifo_full = 1'b0; fifo_wr_err = 1'b0;
  endtask

  initial begin
    int w0;
    #2;
    check("init_gnt", gnt, '0);
    check("init_wr_en", fifo_wr_en, 1'b0);
    check("init_ovf_cnt", ovf_cnt, '0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Single producer, three-beat burst, then rr_ptr should point at 3.
    do_reset();
    drive(4'b0100, 4'b0000, 0, 0);
    drive(4'b0100, 4'b0000, 0, 0);
    check("t1_gnt", gnt, 4'b0100);
    drive(4'b0100, 4'b0000, 0, 0);
    drive(4'b0100, 4'b0100, 0, 0);
    drive(4'b0000, 4'b0000, 0, 0);
    check("t1_released", gnt, 4'b0000);
    drive(4'b1001, 4'b0000, 0, 0);
    drive(4'b1001, 4'b1001, 0, 0);
    check("t1_next_from_ptr3", gnt, 4'b1000);
    drive(4'b0000, 4'b0000, 0, 0);

    // All request, no last: five 8-beat capped grants with one idle cycle between.
    do_reset();
    w0 = wr_seen;
    for (int c = 0; c < 46; c++) drive(4'b1111, 4'b0000, 0, 0);
    check("t2_beats", wr_seen - w0, 40);
    check("t2_idle_gap", gnt, 4'b0000);
    drive(4'b0000, 4'b0000, 0, 0);

    // Owner 1 stalls for 5 cycles and resumes; then a long stall revokes the grant.
    do_reset();
    for (int c = 0; c < 4; c++) drive(4'b0110, 4'b0000, 0, 0);
    for (int c = 0; c < 5; c++) drive(4'b0110, 4'b0000, 1, 0);
    check("t3_stall_gnt", gnt, 4'b0010);
    check("t3_stall_no_wr", fifo_wr_en, 1'b0);
    for (int c = 0; c < 2; c++) drive(4'b0110, 4'b0000, 0, 0);
    for (int c = 0; c < 20; c++) drive(4'b0110, 4'b0000, 1, 0);
    check("t3_revoked", gnt, 4'b0000);
    drive(4'b0110, 4'b0000, 0, 0);
    drive(4'b0110, 4'b0000, 0, 0);
    check("t3_next_owner", gnt, 4'b0100);
    drive(4'b0000, 4'b0000, 0, 0);

    // Owner 3 abandons after two beats; pointer wraps to 0.
    do_reset();
    for (int c = 0; c < 3; c++) drive(4'b1000, 4'b0000, 0, 0);
    drive(4'b0000, 4'b0000, 0, 0);
    drive(4'b1001, 4'b0000, 0, 0);
    check("t4_released", gnt, 4'b0000);
    drive(4'b1001, 4'b0000, 0, 0);
    check("t4_wrap_to_0", gnt, 4'b0001);
    drive(4'b0000, 4'b0000, 0, 0);

    // Overflow counter saturation, then reset in the middle of a burst.
    do_reset();
    for (int c = 0; c < 260; c++) drive(4'b1111, N'($urandom_range(0, 15)), 0, 1);
    drive(4'b1111, 4'b0000, 0, 0);
    check("t5_ovf_err", ovf_err, 1'b1);
    check("t5_ovf_cnt_sat", ovf_cnt, 8'd255);
    drive(4'b1111, 4'b0000, 0, 0);
    drive(4'b1111, 4'b0000, 0, 0);
    do_reset();

    // Full from reset: nothing is ever granted or written.
    w0 = wr_seen;
    for (int c = 0; c < 30; c++) drive(4'b1111, 4'b0000, 1, 0);
    check("t6_no_gnt", gnt, 4'b0000);
    check("t6_no_writes", wr_seen - w0, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] r, l;
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(0, 9) < 7);
        l[i] = ($urandom_range(0, 9) < 2);
      end
      drive(r, l, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5));
    end
    drive(4'b0000, 4'b0000, 0, 0);
    drive(4'b0000, 4'b0000, 0, 0);
    @(negedge CLK);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
